// File: rtl/mcc_sub_serial.sv
// Digit-serial subtractor: diff = a - b - bin, one nibble per clock through a
// propagate/generate carry chain on ~b. Optional signed overflow output via MCC_SUB_OVF_EN.
module mcc_sub_serial #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bout
`ifdef MCC_SUB_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int N  = SIZE / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [SIZE-1:0] a_reg, b_reg, diff_reg;
    logic [KW-1:0]   k_reg;
    logic            borrow_reg;
    logic            out_valid_reg;
    logic            accept, last_step;

    logic [3:0] a_nib, nb_nib, p, g, d;
    logic [4:0] c;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_step = (state_reg == RUN) && (k_reg == KW'(N - 1));

    // Nibble slice selected by the step counter; b is inverted so the chain adds.
    assign a_nib  = a_reg[{k_reg, 2'b00} +: 4];
    assign nb_nib = ~b_reg[{k_reg, 2'b00} +: 4];
    assign c[0]   = ~borrow_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chain
            assign p[gi]   = a_nib[gi] ^ nb_nib[gi];
            assign g[gi]   = a_nib[gi] & nb_nib[gi];
            assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
            assign d[gi]   = p[gi] ^ c[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            diff_reg      <= '0;
            k_reg         <= '0;
            borrow_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg      <= a;
                b_reg      <= b;
                borrow_reg <= bin;
                k_reg      <= '0;
            end else if (state_reg == RUN) begin
                diff_reg[{k_reg, 2'b00} +: 4] <= d;
                borrow_reg                    <= ~c[4];
                k_reg                         <= k_reg + 1'b1;
            end
            if (last_step) begin
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef MCC_SUB_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (last_step) begin
            ovf_reg <= c[4] ^ c[3];
        end
    end

    assign ovf = ovf_reg;
`endif

    assign diff      = diff_reg;
    assign bout      = borrow_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mcc_sub_serial.sv
// Directed self-checking bench for mcc_sub_serial (SIZE=16); ovf checks only
// when MCC_SUB_OVF_EN is defined.
module tb_mcc_sub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
`ifdef MCC_SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcc_sub_serial #(.SIZE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef MCC_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Launch one operation and wait for out_valid; cycles=99 means timeout.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic bi, output int cycles);
        @(negedge clk);
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        bin      = 1'b0;
        cycles   = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                cycles = i;
                break;
            end
        end
        $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d latency=%0d",
                 av, bv, bi, diff, bout, cycles);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (diff !== 16'h0)     begin errors++; $display("FAIL reset_diff got %h want 0000", diff); end
        checks++; if (bout !== 1'b0)      begin errors++; $display("FAIL reset_bout got %b want 0", bout); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int cyc;
        start_op(16'h1234, 16'h0234, 1'b0, cyc);
        checks++; if (cyc !== 4)          begin errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
        checks++; if (diff !== 16'h1000)  begin errors++; $display("FAIL basic_diff got %h want 1000", diff); end
        checks++; if (bout !== 1'b0)      begin errors++; $display("FAIL basic_bout got %b want 0", bout); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
        finish_op();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_clear got %b want 0", out_valid); end
    endtask

    task automatic test_underflow();
        int cyc;
        start_op(16'h0000, 16'h0001, 1'b0, cyc);
        checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL uflow1_diff got %h want ffff", diff); end
        checks++; if (bout !== 1'b1)     begin errors++; $display("FAIL uflow1_bout got %b want 1", bout); end
        finish_op();
        start_op(16'h0000, 16'h0000, 1'b1, cyc);
        checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL uflow_bin_diff got %h want ffff", diff); end
        checks++; if (bout !== 1'b1)     begin errors++; $display("FAIL uflow_bin_bout got %b want 1", bout); end
        finish_op();
    endtask

    task automatic test_ripple();
        int cyc;
        start_op(16'h0100, 16'h0001, 1'b0, cyc);
        checks++; if (diff !== 16'h00FF) begin errors++; $display("FAIL ripple_diff got %h want 00ff", diff); end
        checks++; if (bout !== 1'b0)     begin errors++; $display("FAIL ripple_bout got %b want 0", bout); end
        finish_op();
    endtask

`ifdef MCC_SUB_OVF_EN
    task automatic test_overflow();
        int cyc;
        start_op(16'h8000, 16'h0001, 1'b0, cyc);
        checks++; if (diff !== 16'h7FFF) begin errors++; $display("FAIL ovf1_diff got %h want 7fff", diff); end
        checks++; if (bout !== 1'b0)     begin errors++; $display("FAIL ovf1_bout got %b want 0", bout); end
        checks++; if (ovf !== 1'b1)      begin errors++; $display("FAIL ovf1_ovf got %b want 1", ovf); end
        finish_op();
        start_op(16'h7FFF, 16'h0001, 1'b0, cyc);
        checks++; if (diff !== 16'h7FFE) begin errors++; $display("FAIL ovf0_diff got %h want 7ffe", diff); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL ovf0_ovf got %b want 0", ovf); end
        finish_op();
    endtask
`endif

    task automatic test_backpressure();
        int cyc;
        start_op(16'h1234, 16'h5678, 1'b0, cyc);
        checks++; if (diff !== 16'hBBBC) begin errors++; $display("FAIL bp_diff got %h want bbbc", diff); end
        checks++; if (bout !== 1'b1)     begin errors++; $display("FAIL bp_bout got %b want 1", bout); end
        for (int i = 0; i < 6; i++) begin
            a        = 16'h0F0F ^ 16'(i);
            b        = 16'h00F0;
            bin      = i[0];
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++; if (diff !== 16'hBBBC)  begin errors++; $display("FAIL bp_hold_diff[%0d] got %h want bbbc", i, diff); end
            checks++; if (bout !== 1'b1)      begin errors++; $display("FAIL bp_hold_bout[%0d] got %b want 1", i, bout); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
        end
        // Keep in_valid high across the handshake edge: it must not be taken there.
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_no_accept got in_ready %b want 1", in_ready); end
        $display("backpressure: held 6 cycles, released");
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        @(negedge clk);
        a        = 16'h1111;
        b        = 16'h0000;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_out_valid got %b want 0", out_valid); end
        checks++; if (diff !== 16'h0)     begin errors++; $display("FAIL rst_run_diff got %h want 0000", diff); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_run_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_run_hold_in_ready got %b want 1", in_ready); end
        checks++; if (diff !== 16'h0)     begin errors++; $display("FAIL rst_run_hold_diff got %h want 0000", diff); end
        rst_n = 1'b1;
        start_op(16'h00FF, 16'h000F, 1'b0, cyc);
        checks++; if (cyc !== 4)          begin errors++; $display("FAIL rst_after_latency got %0d want 4", cyc); end
        checks++; if (diff !== 16'h00F0)  begin errors++; $display("FAIL rst_after_diff got %h want 00f0", diff); end
        checks++; if (bout !== 1'b0)      begin errors++; $display("FAIL rst_after_bout got %b want 0", bout); end
        finish_op();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        bin       = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_ripple();
`ifdef MCC_SUB_OVF_EN
        test_overflow();
`endif
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
